// File: rtl/text_mode_buffer.sv
// Text-mode screen buffer: per-cell {attr,char} store addressed by logical
// row/column, with a rotating top-row offset for hardware scroll and a
// self-timed walker that blanks the whole screen or a single row.
module text_mode_buffer #(
    parameter int                ROWS       = 30,
    parameter int                COLS       = 80,
    parameter int                ROW_BITS   = 5,
    parameter int                COL_BITS   = 7,
    parameter int                CHAR_W     = 8,
    parameter int                ATTR_W     = 8,
    parameter logic [CHAR_W-1:0] CLEAR_CHAR = 8'h20,
    parameter logic [ATTR_W-1:0] CLEAR_ATTR = 8'h07
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                write_valid,
    output logic                write_ready,
    input  logic [ROW_BITS-1:0] write_row,
    input  logic [COL_BITS-1:0] write_col,
    input  logic [CHAR_W-1:0]   write_char,
    input  logic [ATTR_W-1:0]   write_attr,
    input  logic                cmd_clear,
    input  logic                cmd_scroll,
    output logic                busy,
    output logic [ROW_BITS-1:0] top_row,
    input  logic [ROW_BITS-1:0] read_row,
    input  logic [COL_BITS-1:0] read_col,
    output logic [CHAR_W-1:0]   read_char,
    output logic [ATTR_W-1:0]   read_attr
);

    localparam int                  AW       = ROW_BITS + COL_BITS;
    localparam int                  DW       = ATTR_W + CHAR_W;
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS:0]   ROWS_EXT = (ROW_BITS + 1)'(ROWS);
    localparam logic [DW-1:0]       BLANK    = {CLEAR_ATTR, CLEAR_CHAR};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_ALL,
        ST_CLR_ROW
    } state_t;

    // Both operands are below ROWS, so one conditional subtract replaces the modulo.
    function automatic logic [ROW_BITS-1:0] f_phys_row(input logic [ROW_BITS-1:0] row,
                                                      input logic [ROW_BITS-1:0] top);
        logic [ROW_BITS:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= ROWS_EXT) begin
            sum = sum - ROWS_EXT;
        end
        return sum[ROW_BITS-1:0];
    endfunction

    logic [DW-1:0]       r_mem [0:(2**AW)-1];
    state_t              r_state;
    state_t              w_state_next;
    logic [ROW_BITS-1:0] r_top_row;
    logic [ROW_BITS-1:0] r_wrow;
    logic [COL_BITS-1:0] r_wcol;
    logic [CHAR_W-1:0]   r_rd_char;
    logic [ATTR_W-1:0]   r_rd_attr;
    logic                w_busy;
    logic                w_do_clear;
    logic                w_do_scroll;
    logic                w_walk_en;
    logic                w_wr_accept;
    logic                w_wr_in_range;
    logic                w_rd_in_range;
    logic [AW-1:0]       w_wr_addr;
    logic [AW-1:0]       w_rd_addr;
    logic                w_mem_we;
    logic [AW-1:0]       w_mem_waddr;
    logic [DW-1:0]       w_mem_wdata;

    assign w_busy        = (r_state != ST_IDLE);
    assign busy          = w_busy;
    assign write_ready   = ~w_busy;
    assign top_row       = r_top_row;
    assign read_char     = r_rd_char;
    assign read_attr     = r_rd_attr;

    assign w_wr_accept   = write_valid & ~w_busy;
    assign w_wr_in_range = (write_row <= LAST_ROW) && (write_col <= LAST_COL);
    assign w_rd_in_range = (read_row <= LAST_ROW) && (read_col <= LAST_COL);
    assign w_wr_addr     = {f_phys_row(write_row, r_top_row), write_col};
    assign w_rd_addr     = {f_phys_row(read_row, r_top_row), read_col};

    // State register; reset parks the FSM in the full clear so the screen is blanked after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CLR_ALL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: commands are taken only in IDLE, clear has priority over scroll.
    always_comb begin
        w_state_next = r_state;
        w_do_clear   = 1'b0;
        w_do_scroll  = 1'b0;
        w_walk_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_clear) begin
                    w_do_clear   = 1'b1;
                    w_state_next = ST_CLR_ALL;
                end else if (cmd_scroll) begin
                    w_do_scroll  = 1'b1;
                    w_state_next = ST_CLR_ROW;
                end
            end
            ST_CLR_ALL: begin
                w_walk_en = 1'b1;
                if ((r_wrow == LAST_ROW) && (r_wcol == LAST_COL)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLR_ROW: begin
                w_walk_en = 1'b1;
                if (r_wcol == LAST_COL) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Scroll offset: cleared by reset and cmd_clear, advanced with wrap by cmd_scroll.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top_row <= '0;
        end else if (w_do_clear) begin
            r_top_row <= '0;
        end else if (w_do_scroll) begin
            r_top_row <= (r_top_row == LAST_ROW) ? '0 : r_top_row + 1'b1;
        end
    end

    // Clear walker position in physical coordinates; a scroll starts on the old top row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrow <= '0;
            r_wcol <= '0;
        end else if (w_do_clear) begin
            r_wrow <= '0;
            r_wcol <= '0;
        end else if (w_do_scroll) begin
            r_wrow <= r_top_row;
            r_wcol <= '0;
        end else if (w_walk_en) begin
            if (r_wcol == LAST_COL) begin
                r_wcol <= '0;
                r_wrow <= (r_wrow == LAST_ROW) ? '0 : r_wrow + 1'b1;
            end else begin
                r_wcol <= r_wcol + 1'b1;
            end
        end
    end

    // Single write port: walker while busy, otherwise the accepted in-range CPU write.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_wr_addr;
        w_mem_wdata = {write_attr, write_char};
        if (w_walk_en) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {r_wrow, r_wcol};
            w_mem_wdata = BLANK;
        end else if (w_wr_accept && w_wr_in_range) begin
            w_mem_we = 1'b1;
        end
    end

    // Cell storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Registered read; same-edge write is not visible, so the old cell contents come back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_char <= '0;
            r_rd_attr <= '0;
        end else if (w_rd_in_range) begin
            {r_rd_attr, r_rd_char} <= r_mem[w_rd_addr];
        end else begin
            r_rd_char <= CLEAR_CHAR;
            r_rd_attr <= CLEAR_ATTR;
        end
    end

endmodule
